// File: rtl/rd_pntrs_and_empty.sv
// Read-domain pointer, empty flag and fill level for a dual-clock FIFO.
// Synchronises the Gray write pointer and exports the registered Gray read pointer.
module rd_pntrs_and_empty #(
  parameter int unsigned AWIDTH      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              rd_clk_i,
  input  logic              aclr_i,
  input  logic              rd_req_i,
  input  logic [AWIDTH:0]   wr_pntr_gray_i,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic [AWIDTH:0]   rd_pntr_gray_rd_o,
  output logic              rd_empty_o,
  output logic [AWIDTH:0]   rd_usedw_o,
  output logic              rd_valid_o,
  output logic              rd_underflow_o
);

  localparam int unsigned PW = AWIDTH + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] usedw_q, usedw_d;
  logic [PW-1:0] wq_gray_c, wq_bin_c;
  logic          empty_q, empty_d;
  logic          valid_q, valid_d;
  logic          underflow_q, underflow_d;
  logic          rd_ack_c;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], wr_pntr_gray_i};
    wq_gray_c   = sync_q[SYNC_STAGES-1];
    wq_bin_c    = '0;
    // Gray to binary: each bit is the XOR of itself and all higher bits
    for (int unsigned i = 0; i < PW; i++) begin
      wq_bin_c[i] = ^(wq_gray_c >> i);
    end
    rd_ack_c    = rd_req_i & ~empty_q;
    rd_bin_d    = rd_bin_q + PW'(rd_ack_c);
    rd_gray_d   = rd_bin_d ^ (rd_bin_d >> 1);
    // Look-ahead compare so empty rises on the edge that takes the last word
    empty_d     = (rd_gray_d == wq_gray_c);
    usedw_d     = wq_bin_c - rd_bin_d;
    valid_d     = rd_ack_c;
    underflow_d = underflow_q | (rd_req_i & empty_q);
  end

  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      sync_q      <= '0;
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      usedw_q     <= '0;
      empty_q     <= 1'b1;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      usedw_q     <= usedw_d;
      empty_q     <= empty_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_pntr_o         = rd_bin_q[AWIDTH-1:0];
  assign rd_pntr_gray_rd_o = rd_gray_q;
  assign rd_empty_o        = empty_q;
  assign rd_usedw_o        = usedw_q;
  assign rd_valid_o        = valid_q;
  assign rd_underflow_o    = underflow_q;

endmodule
